// File: rtl/watch_set_ctrl_if.sv
// Watch controller bus: user buttons, current watch time, and the controller's
// tick/load/edit-time/mode outputs. The controller takes the master view; the
// watch core and button logic take the slave view.
interface watch_set_ctrl_if;
    logic       btn_mode;
    logic       btn_inc;
    logic [3:0] cur_hour;
    logic [5:0] cur_minute;
    logic       tick;
    logic       load;
    logic [3:0] load_hour;
    logic [5:0] load_minute;
    logic [1:0] mode;

    modport master (
        input  btn_mode, btn_inc, cur_hour, cur_minute,
        output tick, load, load_hour, load_minute, mode
    );

    modport slave (
        output btn_mode, btn_inc, cur_hour, cur_minute,
        input  tick, load, load_hour, load_minute, mode
    );
endinterface

// File: rtl/watch_set_ctrl.sv
// Watch set-time controller: generates the 1-cycle time-base tick and runs the
// button-driven RUN -> SET_H -> SET_M -> RUN edit sequence, writing the edited
// time back with a 1-cycle load strobe. All outputs are registered.
// Optional feature: define AUTO_REPEAT_EN to auto-repeat increments while btn_inc
// is held in the edit states.
module watch_set_ctrl #(
    parameter int unsigned TICK_DIV    = 4,
    parameter int unsigned HOUR_MAX    = 11,
    parameter int unsigned REPEAT_DLY  = 8,
    parameter int unsigned REPEAT_RATE = 4
) (
    input logic               clk,
    input logic               rstn,
    watch_set_ctrl_if.master  bus
);

    localparam int unsigned PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_DIV - 1);
    localparam logic [3:0]    HOUR_LAST  = 4'(HOUR_MAX);
    localparam logic [5:0]    MIN_LAST   = 6'd59;

    typedef enum logic [1:0] {
        StRun  = 2'd0,
        StSetH = 2'd1,
        StSetM = 2'd2
    } state_e;

    state_e         state_q, state_d;
    logic [PW-1:0]  presc_q, presc_d;
    logic           tick_q, tick_d;
    logic           load_q, load_d;
    logic [3:0]     hour_q, hour_d;
    logic [5:0]     minute_q, minute_d;
    logic           mode_prev_q, inc_prev_q;

    logic mode_press, inc_press, rpt_fire, inc_evt;

    assign mode_press = bus.btn_mode & ~mode_prev_q;
    assign inc_press  = bus.btn_inc & ~inc_prev_q;
    assign inc_evt    = inc_press | rpt_fire;

`ifdef AUTO_REPEAT_EN
    localparam int unsigned RW = $clog2(REPEAT_DLY + REPEAT_RATE + 1);

    logic [RW-1:0] rpt_q, rpt_d, rpt_next;

    // Hold counter: cycles since press; fires at DLY, then every RATE (folds back to DLY).
    always_comb begin
        rpt_d    = '0;
        rpt_fire = 1'b0;
        rpt_next = rpt_q + RW'(1);
        if (state_q != StRun && !mode_press && bus.btn_inc && !inc_press) begin
            if (rpt_next == RW'(REPEAT_DLY + REPEAT_RATE)) begin
                rpt_fire = 1'b1;
                rpt_d    = RW'(REPEAT_DLY);
            end else begin
                rpt_fire = (rpt_next == RW'(REPEAT_DLY));
                rpt_d    = rpt_next;
            end
        end
    end

    // Hold counter register.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            rpt_q <= '0;
        end else begin
            rpt_q <= rpt_d;
        end
    end
`else
    logic unused_rpt;
    assign unused_rpt = ^{REPEAT_DLY, REPEAT_RATE};
    assign rpt_fire   = 1'b0;
`endif

    // Next-state, prescaler and edit-value logic; mode press beats inc press.
    always_comb begin
        state_d  = state_q;
        presc_d  = presc_q;
        tick_d   = 1'b0;
        load_d   = 1'b0;
        hour_d   = hour_q;
        minute_d = minute_q;
        unique case (state_q)
            StRun: begin
                if (mode_press) begin
                    state_d  = StSetH;
                    hour_d   = (bus.cur_hour > HOUR_LAST) ? 4'd0 : bus.cur_hour;
                    minute_d = (bus.cur_minute > MIN_LAST) ? 6'd0 : bus.cur_minute;
                    presc_d  = '0;
                end else if (presc_q == PRESC_LAST) begin
                    presc_d = '0;
                    tick_d  = 1'b1;
                end else begin
                    presc_d = presc_q + PW'(1);
                end
            end
            StSetH: begin
                if (mode_press) begin
                    state_d = StSetM;
                end else if (inc_evt) begin
                    hour_d = (hour_q == HOUR_LAST) ? 4'd0 : hour_q + 4'd1;
                end
            end
            StSetM: begin
                if (mode_press) begin
                    state_d = StRun;
                    load_d  = 1'b1;
                    presc_d = '0;
                end else if (inc_evt) begin
                    minute_d = (minute_q == MIN_LAST) ? 6'd0 : minute_q + 6'd1;
                end
            end
            default: begin
                state_d = StRun;
                presc_d = '0;
            end
        endcase
    end

    // State, output and button-history registers.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q     <= StRun;
            presc_q     <= '0;
            tick_q      <= 1'b0;
            load_q      <= 1'b0;
            hour_q      <= 4'd0;
            minute_q    <= 6'd0;
            mode_prev_q <= 1'b0;
            inc_prev_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            presc_q     <= presc_d;
            tick_q      <= tick_d;
            load_q      <= load_d;
            hour_q      <= hour_d;
            minute_q    <= minute_d;
            mode_prev_q <= bus.btn_mode;
            inc_prev_q  <= bus.btn_inc;
        end
    end

    assign bus.tick        = tick_q;
    assign bus.load        = load_q;
    assign bus.load_hour   = hour_q;
    assign bus.load_minute = minute_q;
    assign bus.mode        = state_q;

endmodule

// File: tb/tb_watch_set_ctrl.sv
// Bench for watch_set_ctrl: a behavioural model predicts the outputs after each
// clock edge and queues them; a monitor on the falling edge pops and compares.
module tb_watch_set_ctrl;

    localparam int TD   = 4;
    localparam int HMAX = 11;
    localparam int DLY  = 8;
    localparam int RATE = 4;

    typedef struct {
        int tick;
        int load;
        int hour;
        int minute;
        int mode;
    } exp_t;

    logic clk  = 1'b0;
    logic rstn = 1'b0;

    watch_set_ctrl_if bus();

    watch_set_ctrl #(
        .TICK_DIV   (TD),
        .HOUR_MAX   (HMAX),
        .REPEAT_DLY (DLY),
        .REPEAT_RATE(RATE)
    ) dut (
        .clk (clk),
        .rstn(rstn),
        .bus (bus)
    );

    always #5 clk = ~clk;

    exp_t q[$];
    int   checks      = 0;
    int   errors      = 0;
    int   dut_loads   = 0;
    int   model_loads = 0;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
        end
    endtask

    // Reference model: 0=RUN 1=SET_H 2=SET_M, times held as plain integers.
    initial begin
        int  m_mode, m_h, m_m, m_div, m_hold, m_tick, m_load;
        bit  m_pm, m_pi, pm, pi, bm, bi, inc_evt;
        exp_t e;
        m_mode = 0; m_h = 0; m_m = 0; m_div = 0; m_hold = 0; m_pm = 0; m_pi = 0;
        forever begin
            @(posedge clk or negedge rstn);
            if (!rstn) begin
                m_mode = 0; m_h = 0; m_m = 0; m_div = 0; m_hold = 0; m_pm = 0; m_pi = 0;
                q.delete();
            end else begin
                bm = bus.btn_mode;
                bi = bus.btn_inc;
                pm = bm && !m_pm;
                pi = bi && !m_pi;
                inc_evt = pi;
                // Cycles the inc button has been held since it was pressed (edit states only).
                if (m_mode != 0 && !pm && bi) begin
                    m_hold = pi ? 0 : m_hold + 1;
`ifdef AUTO_REPEAT_EN
                    if (!pi && m_hold >= DLY && (m_hold - DLY) % RATE == 0) inc_evt = 1;
`endif
                end else begin
                    m_hold = 0;
                end
                m_tick = 0;
                m_load = 0;
                case (m_mode)
                    0: begin
                        if (pm) begin
                            m_mode = 1;
                            m_h    = (bus.cur_hour > HMAX) ? 0 : int'(bus.cur_hour);
                            m_m    = (bus.cur_minute > 59) ? 0 : int'(bus.cur_minute);
                            m_div  = 0;
                        end else begin
                            m_div  = (m_div + 1) % TD;
                            m_tick = (m_div == 0);
                        end
                    end
                    1: begin
                        if (pm) m_mode = 2;
                        else if (inc_evt) m_h = (m_h + 1) % (HMAX + 1);
                    end
                    default: begin
                        if (pm) begin
                            m_mode = 0;
                            m_load = 1;
                            m_div  = 0;
                        end else if (inc_evt) begin
                            m_m = (m_m + 1) % 60;
                        end
                    end
                endcase
                m_pm = bm;
                m_pi = bi;
                if (m_load != 0) model_loads++;
                e.tick = m_tick; e.load = m_load; e.hour = m_h; e.minute = m_m; e.mode = m_mode;
                q.push_back(e);
            end
        end
    end

    // Monitor: compares DUT outputs away from the active edge.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (!rstn) begin
                check("rst_tick", int'(bus.tick), 0);
                check("rst_load", int'(bus.load), 0);
                check("rst_hour", int'(bus.load_hour), 0);
                check("rst_minute", int'(bus.load_minute), 0);
                check("rst_mode", int'(bus.mode), 0);
            end else if (q.size() > 0) begin
                e = q.pop_front();
                if (bus.load) dut_loads++;
                check("tick", int'(bus.tick), e.tick);
                check("load", int'(bus.load), e.load);
                check("load_hour", int'(bus.load_hour), e.hour);
                check("load_minute", int'(bus.load_minute), e.minute);
                check("mode", int'(bus.mode), e.mode);
            end
        end
    end

    task automatic drive(input bit bm, input bit bi, input int n);
        bus.btn_mode = bm;
        bus.btn_inc  = bi;
        repeat (n) begin
            @(posedge clk);
            #2;
        end
    endtask

    task automatic press_mode();
        drive(1'b1, 1'b0, 1);
        drive(1'b0, 1'b0, 1);
    endtask

    task automatic press_inc();
        drive(1'b0, 1'b1, 1);
        drive(1'b0, 1'b0, 1);
    endtask

    task automatic set_cur(input int h, input int m);
        bus.cur_hour   = 4'(h);
        bus.cur_minute = 6'(m);
    endtask

    initial begin
        bus.btn_mode = 1'b0;
        bus.btn_inc  = 1'b0;
        set_cur(0, 0);
        drive(1'b0, 1'b0, 3);
        rstn = 1'b1;
        // Free run: tick every TD cycles.
        drive(1'b0, 1'b0, 13);
        // Full edit with wrap of hour and minute.
        set_cur(11, 59);
        press_mode(); press_inc(); press_mode(); press_inc(); press_mode();
        drive(1'b0, 1'b0, 6);
        // Simultaneous mode and inc in RUN.
        set_cur(5, 30);
        drive(1'b1, 1'b1, 1);
        drive(1'b0, 1'b0, 2);
        press_mode(); press_mode();
        drive(1'b0, 1'b0, 3);
        // Out-of-range capture.
        set_cur(13, 61);
        press_mode();
        drive(1'b0, 1'b0, 2);
        press_mode(); press_mode();
        drive(1'b0, 1'b0, 3);
        // Reset in the middle of SET_M.
        set_cur(3, 42);
        press_mode(); press_mode();
        drive(1'b0, 1'b0, 2);
        rstn = 1'b0;
        drive(1'b0, 1'b0, 2);
        rstn = 1'b1;
        drive(1'b0, 1'b0, 10);
        // Long inc hold in SET_M.
        set_cur(2, 10);
        press_mode(); press_mode();
        drive(1'b0, 1'b1, 20);
        drive(1'b0, 1'b0, 2);
        press_mode();
        drive(1'b0, 1'b0, 4);
        // Randomised levels, holds and occasional resets.
        for (int i = 0; i < 3000; i++) begin
            int n;
            set_cur(int'($urandom_range(0, 15)), int'($urandom_range(0, 63)));
            n = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 25))
                                            : int'($urandom_range(1, 3));
            if ($urandom_range(0, 199) == 0) begin
                rstn = 1'b0;
                drive(1'b0, 1'b0, 1);
                rstn = 1'b1;
            end
            drive(($urandom_range(0, 5) == 0), ($urandom_range(0, 2) == 0), n);
        end
        drive(1'b0, 1'b0, 3);
        check("load_count", dut_loads, model_loads);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
